// File: rtl/pu_or1k_dpram_pkg.sv
// ---------------------------------------------------------------------------
// pu_or1k_dpram_pkg : shared types and helpers for the byte-enable DPRAM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pu_or1k_dpram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int nbytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pu_or1k_dpram_rd_port.sv
// ---------------------------------------------------------------------------
// pu_or1k_dpram_rd_port : one read port with byte-lane bypass and optional output stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pu_or1k_dpram_rd_port
  import pu_or1k_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int OUTPUT_REG    = 0,
  parameter int ENABLE_BYPASS = 1,
  localparam int NBYTES       = nbytes(DATA_WIDTH, BYTE_WIDTH),
  localparam int DEPTH        = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] mem_i [DEPTH],
  input  logic                  wr_en_i,
  input  logic [NBYTES-1:0]     wbe_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  rvalid_o
);

  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Lanes being written this cycle are taken from din; the rest see the old word.
  always_comb begin
    w_rdata = mem_i[raddr_i];
    if ((ENABLE_BYPASS != 0) && wr_en_i && (waddr_i == raddr_i)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe_i[i]) begin
          w_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = din_i[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i) begin
        data_q <= w_rdata;
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= valid_q;
          if (valid_q) begin
            out_q <= data_q;
          end
        end
      end

      assign dout_o   = out_q;
      assign rvalid_o = out_valid_q;
    end else begin : g_noreg
      assign dout_o   = data_q;
      assign rvalid_o = valid_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pu_or1k_dpram_be_sclk.sv
// ---------------------------------------------------------------------------
// pu_or1k_dpram_be_sclk : byte-enable RAM, N read ports, single clock, clear-on-reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pu_or1k_dpram_be_sclk
  import pu_or1k_dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_PORTS     = 2,
  parameter int OUTPUT_REG     = 0,
  parameter int ENABLE_BYPASS  = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NBYTES        = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [NBYTES-1:0]                wbe,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [READ_PORTS-1:0]            re,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] dout,
  output logic [READ_PORTS-1:0]            rvalid,
  output logic                             busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_en;

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clr
      clr_state_e            state_q, state_d;
      logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= CLEAR;
          clr_addr_q <= '0;
        end else begin
          state_q    <= state_d;
          clr_addr_q <= clr_addr_d;
        end
      end

      // The counter rolls to zero on the last word, but the state leaves CLEAR then.
      always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
          CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == '1) begin
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end

      assign w_busy     = (state_q == CLEAR);
      assign w_clr_we   = w_busy && !rst;
      assign w_clr_addr = clr_addr_q;
    end else begin : g_noclr
      assign w_busy     = 1'b0;
      assign w_clr_we   = 1'b0;
      assign w_clr_addr = '0;
    end
  endgenerate

  assign busy    = w_busy;
  assign w_wr_en = we && !w_busy && !rst;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      pu_or1k_dpram_rd_port #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .OUTPUT_REG    (OUTPUT_REG),
        .ENABLE_BYPASS (ENABLE_BYPASS)
      ) u_rd_port (
        .clk      (clk),
        .rst      (rst),
        .rd_en_i  (re[p] && !w_busy && !rst),
        .raddr_i  (raddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .mem_i    (mem_q),
        .wr_en_i  (w_wr_en),
        .wbe_i    (wbe),
        .waddr_i  (waddr),
        .din_i    (din),
        .dout_o   (dout[p*DATA_WIDTH +: DATA_WIDTH]),
        .rvalid_o (rvalid[p])
      );
    end
  endgenerate

endmodule

`default_nettype wire
